// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// instruction fields, ALU operations, datapath mux selects and the
// bundle of control strobes driven by the sequencer.
package multicycle_pkg;

  // State encodings (visible on the debug state port)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXE    = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_EXE    = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations; zero-extended onto the alu_ctrl port
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Which rule the ALU decoder applies in the current state
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,  // address / PC arithmetic, or don't-care
    CLS_SUB   = 2'd1,  // branch compare
    CLS_RTYPE = 2'd2,  // operation from funct
    CLS_ITYPE = 2'd3   // operation from opcode
  } alu_cls_t;

  // ALU B operand select
  localparam logic [1:0] ASB_RT     = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BR     = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  // Datapath strobes and selects produced by the output decoder
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic       illegal;
  } ctrl_t;

  // State entered after DECODE; S_FETCH means the opcode is not supported
  function automatic logic [3:0] decode_target(input logic [5:0] op,
                                               input bit has_jump);
    case (op)
      OP_RTYPE:       return S_R_EXE;
      OP_LW, OP_SW:   return S_MEM_ADDR;
      OP_BEQ:         return S_BRANCH;
      OP_ADDI, OP_ORI: return S_I_EXE;
      OP_J:           return has_jump ? S_JUMP : S_FETCH;
      default:        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU operation decoder: maps the state's ALU class plus the instruction
// fields to an ALU operation, and flags unsupported R-type funct codes.
module alu_dec
  import multicycle_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    op,
  output logic       funct_bad
);

  // Pure lookup; unknown funct falls back to ADD so the sequence can finish
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    op        = ALU_ADD;
    funct_bad = 1'b0;
    case (cls)
      CLS_SUB: op = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: funct_bad = 1'b1;
        endcase
      end
      CLS_ITYPE: op = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      default:   op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit. A state register sequences
// fetch/decode/execute/memory/writeback; memory states wait on mem_ready.
// Outputs are decoded from state, with pc_write/ir_write in FETCH and
// pc_write in BRANCH also qualified by mem_ready / zero.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter bit HAS_JUMP  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem2reg,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           ext_op,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic [3:0]           state,
  output logic                 illegal
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  alu_cls_t   cls;
  alu_op_t    alu_op;
  logic       funct_bad;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps the register update race-free.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state sequencing; memory states hold until mem_ready
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_target(opcode, HAS_JUMP);
      S_MEM_ADDR: state_d = opcode[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXE:    state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_I_EXE:    state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // ALU class per state; writeback states keep the execute-state class so
  // alu_ctrl holds steady across execute and writeback
  always_comb begin
    cls = CLS_ADD;
    case (state_q)
      S_R_EXE, S_R_WB: cls = CLS_RTYPE;
      S_I_EXE, S_I_WB: cls = CLS_ITYPE;
      S_BRANCH:        cls = CLS_SUB;
      default:         cls = CLS_ADD;
    endcase
  end

  alu_dec u_alu_dec (
    .cls       (cls),
    .opcode    (opcode),
    .funct     (funct),
    .op        (alu_op),
    .funct_bad (funct_bad)
  );

  // Output decode; everything forced low while rst is asserted
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ASB_FOUR;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ASB_IMM_SH;
        ctrl.ext_op    = EXT_SIGN;
        ctrl.illegal   = (decode_target(opcode, HAS_JUMP) == S_FETCH);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
        ctrl.ext_op    = EXT_SIGN;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem2reg   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_RT;
        ctrl.illegal   = funct_bad;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_RT;
        ctrl.pc_src    = PC_BR;
        ctrl.pc_write  = zero;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      S_I_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
        ctrl.ext_op    = (opcode == OP_ORI) ? EXT_ZERO : EXT_SIGN;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = (opcode == OP_ORI) ? EXT_ZERO : EXT_SIGN;
      end
      default: ctrl.illegal = 1'b1;  // unused codes recover via FETCH
    endcase
    if (rst) ctrl = '0;
  end

  assign pc_write  = ctrl.pc_write;
  assign pc_src    = ctrl.pc_src;
  assign ir_write  = ctrl.ir_write;
  assign iord      = ctrl.iord;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign mem2reg   = ctrl.mem2reg;
  assign reg_write = ctrl.reg_write;
  assign reg_dst   = ctrl.reg_dst;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign ext_op    = ctrl.ext_op;
  assign illegal   = ctrl.illegal;
  assign alu_ctrl  = rst ? '0 : ALUCTRL_W'(alu_op);
  assign state     = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Every output is packed into one
// 23-bit vector and compared each cycle against hand-written expectations.
// A second instance with HAS_JUMP=0 shares the inputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic       pc_write, ir_write, iord, mem_read, mem_write, mem2reg;
  logic       reg_write, reg_dst, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b, ext_op;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  logic       n_pc_write, n_ir_write, n_iord, n_mem_read, n_mem_write, n_mem2reg;
  logic       n_reg_write, n_reg_dst, n_alu_src_a, n_illegal;
  logic [1:0] n_pc_src, n_alu_src_b, n_ext_op;
  logic [2:0] n_alu_ctrl;
  logic [3:0] n_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem2reg(mem2reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_ctrl(alu_ctrl), .state(state), .illegal(illegal)
  );

  multicycle_ctrl #(.ALUCTRL_W(3), .HAS_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(n_pc_write), .pc_src(n_pc_src),
    .ir_write(n_ir_write), .iord(n_iord), .mem_read(n_mem_read),
    .mem_write(n_mem_write), .mem2reg(n_mem2reg), .reg_write(n_reg_write),
    .reg_dst(n_reg_dst), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .ext_op(n_ext_op), .alu_ctrl(n_alu_ctrl), .state(n_state),
    .illegal(n_illegal)
  );

  // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem2reg,
  //  reg_write, reg_dst, alu_src_a, alu_src_b, ext_op, alu_ctrl, state, illegal}
  wire [22:0] obs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                     mem2reg, reg_write, reg_dst, alu_src_a, alu_src_b,
                     ext_op, alu_ctrl, state, illegal};
  wire [22:0] obs_nj = {n_pc_write, n_pc_src, n_ir_write, n_iord, n_mem_read,
                        n_mem_write, n_mem2reg, n_reg_write, n_reg_dst,
                        n_alu_src_a, n_alu_src_b, n_ext_op, n_alu_ctrl,
                        n_state, n_illegal};

  localparam logic [22:0] PCW  = 23'h1 << 22;
  localparam logic [22:0] IRW  = 23'h1 << 19;
  localparam logic [22:0] IORD = 23'h1 << 18;
  localparam logic [22:0] MR   = 23'h1 << 17;
  localparam logic [22:0] MW   = 23'h1 << 16;
  localparam logic [22:0] M2R  = 23'h1 << 15;
  localparam logic [22:0] RW   = 23'h1 << 14;
  localparam logic [22:0] RD   = 23'h1 << 13;
  localparam logic [22:0] ASA  = 23'h1 << 12;
  localparam logic [22:0] ILL  = 23'h1;

  function automatic logic [22:0] pcs(input logic [1:0] v); return {21'd0, v} << 20; endfunction
  function automatic logic [22:0] asb(input logic [1:0] v); return {21'd0, v} << 10; endfunction
  function automatic logic [22:0] ext(input logic [1:0] v); return {21'd0, v} << 8;  endfunction
  function automatic logic [22:0] alu(input logic [2:0] v); return {20'd0, v} << 5;  endfunction
  function automatic logic [22:0] st (input logic [3:0] v); return {19'd0, v} << 1;  endfunction

  // Hand-derived per-state expectations
  logic [22:0] e_f1, e_f0, e_d, e_di, e_ma, e_mrd, e_mwb, e_mwr, e_j;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; funct = 6'd0; zero = 1'b1;
    tick; tick;
    #1;
    vectors++;
    if (obs !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required %h", obs, 23'd0);
    end
    vectors++;
    if (obs_nj !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs_nj: got %h, required %h", obs_nj, 23'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw;
    logic [22:0] e [$];
    bit          r [$];
    opcode = 6'b100011;
    e = '{e_f1, e_d, e_ma, e_mrd, e_mwb, e_f1};
    r = '{1, 1, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL lw cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      if (i < e.size() - 1) tick;
    end
  endtask

  task automatic test_sw_stall;
    logic [22:0] e [$];
    bit          r [$];
    opcode = 6'b101011;
    e = '{e_f1, e_d, e_ma, e_mwr, e_mwr, e_mwr, e_mwr, e_f1};
    r = '{1, 1, 1, 0, 0, 0, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL sw_stall cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      if (i < e.size() - 1) tick;
    end
  endtask

  task automatic test_rtype;
    logic [5:0]  fn  [3] = '{6'b100010, 6'b101010, 6'b000111};
    logic [2:0]  op  [3] = '{3'd1, 3'd4, 3'd0};
    logic [22:0] bad [3] = '{23'd0, 23'd0, ILL};
    logic [22:0] e [$];
    opcode = 6'b000000;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      funct = fn[k];
      e = '{e_f1, e_d, ASA | alu(op[k]) | st(6) | bad[k],
            RW | RD | alu(op[k]) | st(7), e_f1};
      for (int i = 0; i < e.size(); i++) begin
        #1;
        vectors++;
        if (obs !== e[i]) begin
          miscompares++;
          $display("FAIL rtype funct %b cycle %0d: got %h, required %h", fn[k], i, obs, e[i]);
        end
        if (i < e.size() - 1) tick;
      end
    end
  endtask

  task automatic test_beq;
    logic [22:0] e [$];
    bit          r [$];
    opcode = 6'b000100;
    zero = 1'b1;
    e = '{e_f0, e_f1, e_d, PCW | pcs(1) | ASA | alu(1) | st(8), e_f1};
    r = '{0, 1, 1, 1, 1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL beq_taken cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      if (i < e.size() - 1) tick;
    end
    zero = 1'b0;
    e = '{e_f1, e_d, pcs(1) | ASA | alu(1) | st(8), e_f1};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = 1'b1; #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL beq_not_taken cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      if (i < e.size() - 1) tick;
    end
  endtask

  task automatic test_itype;
    logic [5:0]  opc [2] = '{6'b001101, 6'b001000};
    logic [1:0]  ex  [2] = '{2'b00, 2'b01};
    logic [2:0]  op  [2] = '{3'd3, 3'd0};
    logic [22:0] e [$];
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = opc[k];
      e = '{e_f1, e_d, ASA | asb(2) | ext(ex[k]) | alu(op[k]) | st(10),
            RW | ext(ex[k]) | alu(op[k]) | st(11), e_f1};
      for (int i = 0; i < e.size(); i++) begin
        #1;
        vectors++;
        if (obs !== e[i]) begin
          miscompares++;
          $display("FAIL itype op %b cycle %0d: got %h, required %h", opc[k], i, obs, e[i]);
        end
        if (i < e.size() - 1) tick;
      end
    end
  endtask

  task automatic test_illegal_opcode;
    logic [22:0] e [$];
    opcode = 6'b111111;
    mem_ready = 1'b1;
    e = '{e_f1, e_di, e_f1};
    for (int i = 0; i < e.size(); i++) begin
      #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL illegal_op cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      vectors++;
      if (obs_nj !== e[i]) begin
        miscompares++;
        $display("FAIL illegal_op_nj cycle %0d: got %h, required %h", i, obs_nj, e[i]);
      end
      if (i < e.size() - 1) tick;
    end
  endtask

  task automatic test_jump;
    logic [22:0] e  [$];
    logic [22:0] en [$];
    opcode = 6'b000010;
    mem_ready = 1'b1;
    e  = '{e_f1, e_d,  e_j};
    en = '{e_f1, e_di, e_f1};
    for (int i = 0; i < e.size(); i++) begin
      #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL jump cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      vectors++;
      if (obs_nj !== en[i]) begin
        miscompares++;
        $display("FAIL jump_disabled cycle %0d: got %h, required %h", i, obs_nj, en[i]);
      end
      tick;
    end
    vectors++;
    if (obs !== e_f1) begin
      miscompares++;
      $display("FAIL jump_return: got %h, required %h", obs, e_f1);
    end
    // the two instances now differ in phase; realign them
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  task automatic test_reset_in_stall;
    logic [22:0] e [$];
    bit          r [$];
    opcode = 6'b100011;
    e = '{e_f1, e_d, e_ma, e_mrd, e_mrd};
    r = '{1, 1, 1, 0, 0};
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin
        miscompares++;
        $display("FAIL rst_stall cycle %0d: got %h, required %h", i, obs, e[i]);
      end
      tick;
    end
    rst = 1'b1; mem_ready = 1'b0; #1;
    vectors++;
    if (obs !== 23'd0) begin
      miscompares++;
      $display("FAIL rst_stall_outputs: got %h, required %h", obs, 23'd0);
    end
    tick;
    rst = 1'b0; #1;
    vectors++;
    if (obs !== e_f0) begin
      miscompares++;
      $display("FAIL rst_stall_fetch: got %h, required %h", obs, e_f0);
    end
  endtask

  initial begin
    e_f1  = PCW | IRW | MR | asb(1) | st(0);
    e_f0  = MR | asb(1) | st(0);
    e_d   = asb(3) | ext(1) | st(1);
    e_di  = e_d | ILL;
    e_ma  = ASA | asb(2) | ext(1) | st(2);
    e_mrd = MR | IORD | st(3);
    e_mwb = RW | M2R | st(4);
    e_mwr = MW | IORD | st(5);
    e_j   = PCW | pcs(2) | st(9);

    test_reset;
    test_lw;
    test_sw_stall;
    test_rtype;
    test_beq;
    test_itype;
    test_illegal_opcode;
    test_jump;
    test_reset_in_stall;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit: successor to the single-cycle combinational decoder.
- A state machine sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Memory accesses use a ready handshake, so slow memory can stall the sequence.
- Drives the same datapath select and enable signals as before, plus PC/IR write enables, a wider ALU control and an illegal-opcode flag.

Parameters:
- ALUCTRL_W, 3: width of alu_ctrl; must be ≥3.
- HAS_JUMP, 1: 1 enables the J opcode; 0 treats opcode 000010 as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory done with current access
- pc_write  out  1  PC load enable
- pc_src  out  2  next-PC select: 00 ALU result, 01 branch target register, 10 jump target
- ir_write  out  1  IR load enable
- iord  out  1  memory address select: 0 PC, 1 ALU output register
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem2reg  out  1  register writeback select: 1 memory data register, 0 ALU output register
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register select: 1 rd, 0 rt
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs register
- alu_src_b  out  2  ALU B select: 00 rt register, 01 constant 4, 10 extended immediate, 11 extended immediate <<2
- ext_op  out  2  immediate extension: 00 zero, 01 sign
- alu_ctrl  out  ALUCTRL_W  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- state  out  4  current state, for debug
- illegal  out  1  one-cycle pulse on an unknown opcode

Behaviour:
- Reset: state=FETCH; all outputs 0 in the reset cycle.
- First post-reset cycle: FETCH outputs.
- Outputs are decoded from state only (Moore), except pc_write in FETCH and BRANCH.
- State encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5
  - R_EXE 6, R_WB 7, BRANCH 8, JUMP 9, I_EXE 10, I_WB 11
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, ext_op=01, alu_ctrl=ADD (precomputes branch target).
  - Next state by opcode:
    - 000000 → R_EXE
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 001000 (addi) or 001101 (ori) → I_EXE
    - 000010 → JUMP, when HAS_JUMP=1
    - anything else → FETCH, with illegal=1 for this cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=01, ADD. opcode[3]=1 → MEM_WR, else → MEM_RD.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem2reg=1, reg_dst=0. Then → FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready, then → FETCH. No register write.
- R_EXE:
  - alu_src_a=1, alu_src_b=00; then → R_WB.
  - funct mapping: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Any other funct: ADD, and illegal pulses for this cycle. Sequence still completes.
- R_WB: reg_write=1, reg_dst=1, mem2reg=0; alu_ctrl holds the R_EXE value. Then → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write=zero. Then → FETCH.
- JUMP: pc_src=10, pc_write=1. Then → FETCH.
- I_EXE: alu_src_a=1, alu_src_b=10.
  - addi: ext_op=01, ADD.
  - ori: ext_op=00, OR.
  - Then → I_WB.
- I_WB: reg_write=1, reg_dst=0, mem2reg=0; ext_op and alu_ctrl hold the I_EXE values. Then → FETCH.
- Latency with mem_ready held at 1:
  - lw 5 cycles; sw, R-type and I-type 4 cycles; beq and j 3 cycles.
  - Every mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Strobe rules:
  - mem_read and mem_write are never both 1.
  - Strobes hold steady through a stall.
- Unused state codes 12–15 → FETCH on the next cycle, illegal=1, all other outputs 0.
- rst=1 in any state, including mid-stall: next state FETCH and outputs 0 regardless of mem_ready.
- alu_ctrl is zero-padded to ALUCTRL_W.

Decomposition:
- Package multicycle_pkg:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J
  - funct constants
  - ALU op codes
  - alu_src_b and pc_src encodings
- One sub-module, alu_dec: combinational, (state class, opcode, funct) → alu_ctrl plus funct-illegal flag.
- Next-state logic and output decode stay in multicycle_ctrl.

Test Plan:
- Reset, then lw (opcode 100011) with mem_ready=1 → states 0,1,2,3,4,0. reg_write=1 and mem2reg=1 only in state 4; ir_write=1 in cycle 1.
- sw (101011) with mem_ready=0 for 3 cycles in MEM_WR → mem_write=1 for 4 consecutive cycles, iord=1, reg_write never 1, then FETCH.
- R-type funct 100010, then 101010, then 000111:
  - alu_ctrl = 1, then 4, then 0; illegal pulses only on the third instruction.
  - reg_dst=1 in R_WB for all three.
- beq (000100) with zero=1 → pc_write=1 and pc_src=01 in BRANCH; with zero=0 → pc_write=0. Both take 3 cycles.
- ori (001101) → ext_op=00 and alu_ctrl=3 in I_EXE. addi (001000) → ext_op=01 and alu_ctrl=0.
- Opcode 111111 → illegal=1 in DECODE, back to FETCH. With HAS_JUMP=0, opcode 000010 behaves the same. Asserting rst during a MEM_RD stall → FETCH next cycle with all outputs 0.
